// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: credit-limited, in-order fetch front-end between
// the PC and a variable-latency instruction memory.
//   Clk, Reset                 clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr  fetch request channel (word-aligned address)
//   imem_rsp_valid/data        in-order response channel
//   redirect_valid/pc          taken branch/jump: flush queue, drop in-flight data
//   instr_valid/ready/instr/instr_pc  head of queue towards decode
//   queue_count                occupied queue entries
module instr_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [XLEN-1:0]            instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding, outstanding_nxt;
    logic [CW-1:0]   drop_cnt, drop_nxt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW-1:0]   rq_rd, rq_wr;
    logic [31:0]     q_data [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [XLEN-1:0] rq_pc  [DEPTH];

    logic            accept, drop_rsp, enq, deq, credit_ok;
    logic [XLEN-1:0] redirect_target;

    // Event decode for this cycle
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign credit_ok       = ({1'b0, outstanding} + {1'b0, count}) < SW'(DEPTH);
    assign imem_req_valid  = (state != BOOT) & ~redirect_valid & credit_ok;
    assign imem_req_addr   = pc;
    assign accept          = imem_req_valid & imem_req_ready;
    assign drop_rsp        = imem_rsp_valid & (drop_cnt != '0);
    // A response arriving with a redirect is old-stream data: discard it uncounted
    assign enq             = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);
    assign deq             = instr_valid & instr_ready;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);

    assign instr_valid = (count != '0);
    assign instr       = q_data[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign queue_count = count;

    // Next-state and drop-count logic; after a redirect every owed response is stale
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt - CW'(drop_rsp);
        if (redirect_valid) begin
            drop_nxt = outstanding_nxt;
        end
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (drop_nxt != '0) state_nxt = FLUSH;
            FLUSH:   if (drop_nxt == '0) state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    // State, PC, credit counters and the two FIFOs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            rq_rd       <= '0;
            rq_wr       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
                rq_pc[i]  <= '0;
            end
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_nxt;

            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (accept) begin
                pc <= pc + XLEN'(4);
            end

            // Request-PC FIFO tracks every outstanding request, stale or live
            if (accept) begin
                rq_pc[rq_wr] <= pc;
                rq_wr        <= rq_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
                rq_rd <= rq_rd + AW'(1);
            end

            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq) begin
                    q_data[wr_ptr] <= imem_rsp_data;
                    q_pc[wr_ptr]   <= rq_pc[rq_rd];
                    wr_ptr         <= wr_ptr + AW'(1);
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    a_no_overflow: assert property (@(posedge Clk) disable iff (!Reset)
        !(enq && (count == CW'(DEPTH))));
    a_rsp_owed: assert property (@(posedge Clk) disable iff (!Reset)
        imem_rsp_valid |-> (outstanding != '0));

endmodule
